// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO pin controller.
//   - Register indices of the register map (6 and 7 are reserved).
//   - Encoding of the request/response FSM states.
package gpio_pkg;

    localparam int unsigned GPIO_DOUT  = 0;  // rw, pin output levels
    localparam int unsigned GPIO_OE    = 1;  // rw, pin output enables
    localparam int unsigned GPIO_DIN   = 2;  // ro, synchronised pin inputs
    localparam int unsigned GPIO_IEN   = 3;  // rw, interrupt enables
    localparam int unsigned GPIO_IPOL  = 4;  // rw, 1=rising, 0=falling
    localparam int unsigned GPIO_ISTAT = 5;  // w1c, sticky edge status

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } gpio_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser for the asynchronous pin levels.
// Ports:
//   clk_i  in   clock
//   rst_i  in   synchronous active-high reset, clears every stage to 0
//   d_i    in   WIDTH asynchronous input levels
//   q_o    out  WIDTH synchronised levels (last stage of the chain)
module gpio_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_pin_ctrl.sv
// Register-mapped GPIO pin controller.
// Accepts one register request at a time over a valid/ready request port and
// returns one response (for reads and writes) over a valid/ready response port.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the response holds rsp_valid and rsp_rdata stable until rsp_ready is seen.
// Ports:
//   sig_clock     in   clock, all logic rising-edge
//   sig_reset     in   synchronous active-high reset
//   req_valid     in   request valid
//   req_ready     out  controller idle and able to take a request
//   req_write     in   1=write, 0=read
//   req_addr      in   ADDR_W register index
//   req_wdata     in   WIDTH write data
//   rsp_valid     out  response valid
//   rsp_ready     in   response accepted
//   rsp_rdata     out  WIDTH read data, 0 for writes
//   sig_data_in   in   WIDTH asynchronous pin levels
//   sig_data_out  out  WIDTH pin output levels (DOUT)
//   sig_data_oe   out  WIDTH pin output enables (OE), 1=drive
//   irq           out  registered |(ISTAT & IEN)
module gpio_pin_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 3
) (
    input  logic              sig_clock,
    input  logic              sig_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    input  logic [WIDTH-1:0]  sig_data_in,
    output logic [WIDTH-1:0]  sig_data_out,
    output logic [WIDTH-1:0]  sig_data_oe,
    output logic              irq
);

    // Edge detection stays disarmed this many cycles after reset release so
    // that pins already high during reset do not look like rising edges.
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    gpio_state_e      state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] ipol_q, ipol_d;
    logic [WIDTH-1:0] istat_q, istat_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] prev_q;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             irq_q;

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] rise, fall, evt;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] w1c;
    logic             armed;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (sig_clock),
        .rst_i (sig_reset),
        .d_i   (sig_data_in),
        .q_o   (din)
    );

    // Edge detect and arming counter
    assign armed     = (arm_cnt_q == ARM_W'(ARM_CYCLES));
    assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
    assign rise      = din & ~prev_q;
    assign fall      = ~din & prev_q;
    assign evt       = armed ? ((ipol_q & rise) | (~ipol_q & fall)) : '0;

    // Read mux; reserved addresses return 0
    always_comb begin
        rd_val = '0;
        case (32'(req_addr))
            GPIO_DOUT:  rd_val = dout_q;
            GPIO_OE:    rd_val = oe_q;
            GPIO_DIN:   rd_val = din;
            GPIO_IEN:   rd_val = ien_q;
            GPIO_IPOL:  rd_val = ipol_q;
            GPIO_ISTAT: rd_val = istat_q;
            default:    rd_val = '0;
        endcase
    end

    // FSM next state, register writes and status update
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        ien_d   = ien_q;
        ipol_d  = ipol_q;
        rdata_d = rdata_q;
        w1c     = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_RESP;
                    rdata_d = req_write ? '0 : rd_val;
                    if (req_write) begin
                        case (32'(req_addr))
                            GPIO_DOUT:  dout_d = req_wdata;
                            GPIO_OE:    oe_d   = req_wdata;
                            GPIO_IEN:   ien_d  = req_wdata;
                            GPIO_IPOL:  ipol_d = req_wdata;
                            GPIO_ISTAT: w1c    = req_wdata;
                            default:    ;
                        endcase
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new event wins over a clear of the same bit.
        istat_d = (istat_q & ~w1c) | evt;
    end

    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            state_q   <= ST_IDLE;
            dout_q    <= '0;
            oe_q      <= '0;
            ien_q     <= '0;
            ipol_q    <= '0;
            istat_q   <= '0;
            rdata_q   <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            ien_q     <= ien_d;
            ipol_q    <= ipol_d;
            istat_q   <= istat_d;
            rdata_q   <= rdata_d;
            prev_q    <= din;
            arm_cnt_q <= arm_cnt_d;
            irq_q     <= |(istat_q & ien_q);
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rdata    = rdata_q;
    assign sig_data_out = dout_q;
    assign sig_data_oe  = oe_q;
    assign irq          = irq_q;

endmodule
